// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// 8N1 UART receiver feeding the 7-segment display path.
//
// The raw RX pin is brought into the clock domain through a two-flop
// synchroniser. Every FSM decision uses the second flop (rx_s). A falling
// edge on rx_s starts a frame. The start bit is re-checked at its midpoint,
// so a short low glitch returns to IDLE without producing any output.
// The eight data bits are then sampled LSB-first, one full bit period apart,
// which places each sample near the centre of its bit. The stop bit is
// sampled the same way.
//
// A good stop bit loads o_RX_Byte and pulses o_RX_DV for one cycle.
// A low stop bit pulses o_Frame_Err for one cycle and leaves o_RX_Byte
// unchanged. The FSM then waits in BREAK until the line returns high, so a
// line held low (a break condition) reports only one error.
//
// The stop bit is sampled in the middle of the bit, so the FSM is back in IDLE
// before the stop bit ends. A following start edge with no idle gap is still
// caught.
//
// Parameters
//   CLKS_PER_BIT  clocks per UART bit (>= 4). 217 = 25 MHz / 115200 baud.
//
// Ports
//   i_Clk        in   1  system clock
//   i_Rst_n      in   1  asynchronous reset, active low
//   i_RX_Serial  in   1  raw UART line, idle high, asynchronous to i_Clk
//   o_RX_DV      out  1  one-cycle strobe: o_RX_Byte just took a good frame
//   o_RX_Byte    out  8  last correctly framed byte, held between frames
//   o_Frame_Err  out  1  one-cycle strobe: stop bit sampled low
//   o_Busy       out  1  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // HALF uses (N-1)/2 so the start-bit check lands at or just before mid-bit.
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Synchroniser: the first flop may go metastable. Only rx_s is used.
  logic rx_sync_p0;
  logic rx_s;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift_reg;
  logic             sample_en;
  logic             dv_nxt;
  logic             err_nxt;

  // ---- stage p0/s: input synchroniser (reset to idle-high) ----
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= i_RX_Serial;
      rx_s       <= rx_sync_p0;
    end
  end

  // ---- frame FSM: next-state and strobe decode ----
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    sample_en   = 1'b0;
    dv_nxt      = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        clk_cnt_nxt = CNT_ZERO;
        bit_idx_nxt = 3'd0;
        if (!rx_s) begin
          state_nxt = S_START;
        end
      end

      S_START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_nxt = CNT_ZERO;
          // A line that is already high again at mid-start was a glitch.
          state_nxt   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_ONE;
        end
      end

      S_DATA: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_nxt = CNT_ZERO;
          sample_en   = 1'b1;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = 3'd0;
            state_nxt   = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_ONE;
        end
      end

      S_STOP: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_nxt = CNT_ZERO;
          if (rx_s) begin
            dv_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_ONE;
        end
      end

      S_BREAK: begin
        // Stay here until the line recovers. A long break gives one error.
        clk_cnt_nxt = CNT_ZERO;
        bit_idx_nxt = 3'd0;
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt   = S_IDLE;
        clk_cnt_nxt = CNT_ZERO;
        bit_idx_nxt = 3'd0;
      end
    endcase
  end

  // ---- control registers and output strobes ----
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      clk_cnt     <= CNT_ZERO;
      bit_idx     <= 3'd0;
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_RX_Byte   <= 8'h00;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      o_RX_DV     <= dv_nxt;
      o_Frame_Err <= err_nxt;
      if (dv_nxt) begin
        o_RX_Byte <= shift_reg;
      end
    end
  end

  // ---- data capture ----
  // No reset is needed here. A frame overwrites all eight bits before they
  // reach o_RX_Byte. A reset mid-frame therefore simply discards the
  // partial byte.
  always_ff @(posedge i_Clk) begin
    if (sample_en) begin
      shift_reg[bit_idx] <= rx_s;
    end
  end

  assign o_Busy = (state != S_IDLE);

endmodule
